// File: rtl/setare_multi.sv
// setare_multi: time/alarm edit session controller with step buttons, one-cycle commit pulses and inactivity timeout
module setare_multi #(
  parameter int NUM_ALARMS = 2,
  parameter int SEL_W = 1,
  parameter int HOUR_MAX = 23,
  parameter int MIN_MAX = 59,
  parameter logic [31:0] TIMEOUT_CYC = 32'd500000000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  semnal_setare,
  input  logic                  semnal_setare_a,
  input  logic [SEL_W-1:0]      alarm_sel,
  input  logic                  semnal_b1,
  input  logic                  semnal_b2,
  input  logic                  semnal_dir,
  input  logic                  semnal_stop,
  input  logic                  semnal_cancel,
  input  logic [4:0]            ore_curent,
  input  logic [5:0]            minute_curent,
  output logic [4:0]            ore,
  output logic [5:0]            minute,
  output logic [4:0]            edit_ore,
  output logic [5:0]            edit_minute,
  output logic                  load_timp,
  output logic [NUM_ALARMS-1:0] load_alarma,
  output logic                  editing,
  output logic                  timeout_abort
);
  typedef enum logic [1:0] {IDLE, EDIT_T, EDIT_A} state_t;
  state_t st;
  logic b1_q, b2_q, e1, e2, sel_ok, tmo;
  logic [SEL_W-1:0] ch;
  logic [31:0] cnt;
  logic [4:0] sh_h [NUM_ALARMS];
  logic [5:0] sh_m [NUM_ALARMS];
  logic [4:0] pre_h, nxt_h;
  logic [5:0] pre_m, nxt_m;
  assign e1 = semnal_b1 & ~b1_q;
  assign e2 = semnal_b2 & ~b2_q;
  assign tmo = (TIMEOUT_CYC != 32'd0) && (cnt == TIMEOUT_CYC - 32'd1);
  assign nxt_h = !e1 ? edit_ore :
                 semnal_dir ? (edit_ore == 5'd0 ? 5'(HOUR_MAX) : edit_ore - 5'd1) :
                 (edit_ore == 5'(HOUR_MAX) ? 5'd0 : edit_ore + 5'd1);
  assign nxt_m = !e2 ? edit_minute :
                 semnal_dir ? (edit_minute == 6'd0 ? 6'(MIN_MAX) : edit_minute - 6'd1) :
                 (edit_minute == 6'(MIN_MAX) ? 6'd0 : edit_minute + 6'd1);
  always_comb begin
    sel_ok = 1'b0;
    pre_h = '0;
    pre_m = '0;
    for (int i = 0; i < NUM_ALARMS; i++)
      if (alarm_sel == SEL_W'(i)) begin
        sel_ok = 1'b1;
        pre_h = sh_h[i];
        pre_m = sh_m[i];
      end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      st <= IDLE;
      b1_q <= 1'b0;
      b2_q <= 1'b0;
      ch <= '0;
      cnt <= '0;
      ore <= '0;
      minute <= '0;
      edit_ore <= '0;
      edit_minute <= '0;
      load_timp <= 1'b0;
      load_alarma <= '0;
      editing <= 1'b0;
      timeout_abort <= 1'b0;
      for (int i = 0; i < NUM_ALARMS; i++) begin
        sh_h[i] <= '0;
        sh_m[i] <= '0;
      end
    end else begin
      b1_q <= semnal_b1;
      b2_q <= semnal_b2;
      load_timp <= 1'b0;
      load_alarma <= '0;
      timeout_abort <= 1'b0;
      if (st == IDLE) begin
        if (semnal_setare) begin
          st <= EDIT_T;
          editing <= 1'b1;
          edit_ore <= ore_curent;
          edit_minute <= minute_curent;
          cnt <= '0;
        end else if (semnal_setare_a && sel_ok) begin
          st <= EDIT_A;
          editing <= 1'b1;
          ch <= alarm_sel;
          edit_ore <= pre_h;
          edit_minute <= pre_m;
          cnt <= '0;
        end
      end else if (semnal_cancel) begin
        st <= IDLE;
        editing <= 1'b0;
      end else if (semnal_stop) begin
        st <= IDLE;
        editing <= 1'b0;
        ore <= edit_ore;
        minute <= edit_minute;
        load_timp <= st == EDIT_T;
        for (int i = 0; i < NUM_ALARMS; i++)
          if (st == EDIT_A && ch == SEL_W'(i)) begin
            load_alarma[i] <= 1'b1;
            sh_h[i] <= edit_ore;
            sh_m[i] <= edit_minute;
          end
      end else if (tmo) begin
        st <= IDLE;
        editing <= 1'b0;
        timeout_abort <= 1'b1;
      end else begin
        edit_ore <= nxt_h;
        edit_minute <= nxt_m;
        cnt <= (e1 | e2) ? 32'd1 : cnt + 32'd1;
      end
    end
  end
endmodule

// File: tb/tb_setare_multi.sv
// tb_setare_multi: directed table, hand sequences and random stimulus checked against a timestamp-based model
module tb_setare_multi;
  localparam int NA = 2, SW = 2, HM = 23, MM = 59, TO = 16;
  logic clock = 1'b0;
  logic reset, semnal_setare, semnal_setare_a, semnal_b1, semnal_b2, semnal_dir, semnal_stop, semnal_cancel;
  logic [SW-1:0] alarm_sel;
  logic [4:0] ore_curent, ore, edit_ore;
  logic [5:0] minute_curent, minute, edit_minute;
  logic load_timp, editing, timeout_abort;
  logic [NA-1:0] load_alarma;
  int checks = 0, errors = 0;
  int m_mode, m_wh, m_wm, m_ch, m_ore, m_min, m_lt, m_la, m_ab, p1, p2, cyc, act;
  int sh_h [NA];
  int sh_m [NA];
  always #5 clock = ~clock;
  setare_multi #(.NUM_ALARMS(NA), .SEL_W(SW), .HOUR_MAX(HM), .MIN_MAX(MM), .TIMEOUT_CYC(32'(TO))) dut (
    .clock(clock), .reset(reset), .semnal_setare(semnal_setare), .semnal_setare_a(semnal_setare_a),
    .alarm_sel(alarm_sel), .semnal_b1(semnal_b1), .semnal_b2(semnal_b2), .semnal_dir(semnal_dir),
    .semnal_stop(semnal_stop), .semnal_cancel(semnal_cancel), .ore_curent(ore_curent),
    .minute_curent(minute_curent), .ore(ore), .minute(minute), .edit_ore(edit_ore),
    .edit_minute(edit_minute), .load_timp(load_timp), .load_alarma(load_alarma),
    .editing(editing), .timeout_abort(timeout_abort));
  task automatic chk(input string n, input int a, input int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", n, a, e, $time);
    end
  endtask
  task automatic model();
    int e1, e2;
    e1 = (semnal_b1 && !p1) ? 1 : 0;
    e2 = (semnal_b2 && !p2) ? 1 : 0;
    p1 = int'(semnal_b1);
    p2 = int'(semnal_b2);
    m_lt = 0;
    m_la = 0;
    m_ab = 0;
    if (reset) begin
      m_mode = 0; m_wh = 0; m_wm = 0; m_ore = 0; m_min = 0; p1 = 0; p2 = 0;
      for (int i = 0; i < NA; i++) begin sh_h[i] = 0; sh_m[i] = 0; end
    end else if (m_mode == 0) begin
      if (semnal_setare) begin
        m_mode = 1; m_wh = int'(ore_curent); m_wm = int'(minute_curent); act = cyc + 1;
      end else if (semnal_setare_a && int'(alarm_sel) < NA) begin
        m_mode = 2; m_ch = int'(alarm_sel); m_wh = sh_h[m_ch]; m_wm = sh_m[m_ch]; act = cyc + 1;
      end
    end else if (semnal_cancel) m_mode = 0;
    else if (semnal_stop) begin
      m_ore = m_wh;
      m_min = m_wm;
      if (m_mode == 1) m_lt = 1;
      else begin m_la = 1 << m_ch; sh_h[m_ch] = m_wh; sh_m[m_ch] = m_wm; end
      m_mode = 0;
    end else if (cyc - act == TO - 1) begin
      m_ab = 1;
      m_mode = 0;
    end else begin
      if (e1 != 0) m_wh = semnal_dir ? (m_wh + HM) % (HM + 1) : (m_wh + 1) % (HM + 1);
      if (e2 != 0) m_wm = semnal_dir ? (m_wm + MM) % (MM + 1) : (m_wm + 1) % (MM + 1);
      if (e1 != 0 || e2 != 0) act = cyc;
    end
    cyc++;
  endtask
  task automatic tick();
    model();
    @(posedge clock);
    #1;
    chk("ore", int'(ore), m_ore);
    chk("minute", int'(minute), m_min);
    chk("edit_ore", int'(edit_ore), m_wh);
    chk("edit_minute", int'(edit_minute), m_wm);
    chk("load_timp", int'(load_timp), m_lt);
    chk("load_alarma", int'(load_alarma), m_la);
    chk("editing", int'(editing), m_mode != 0 ? 1 : 0);
    chk("timeout_abort", int'(timeout_abort), m_ab);
    chk("load_excl", int'(load_timp && |load_alarma), 0);
  endtask
  task automatic quiet();
    semnal_setare = 0; semnal_setare_a = 0; semnal_b1 = 0; semnal_b2 = 0;
    semnal_dir = 0; semnal_stop = 0; semnal_cancel = 0;
  endtask
  typedef struct {
    int setare, b1, b2, stop;
    int eo, em, o, m, lt, la, ed;
  } vec_t;
  vec_t tv [9];
  initial begin
    int n;
    tv[0] = '{1, 0, 0, 0, 22, 58, 0, 0, 0, 0, 1};
    tv[1] = '{0, 1, 0, 0, 23, 58, 0, 0, 0, 0, 1};
    tv[2] = '{0, 0, 0, 0, 23, 58, 0, 0, 0, 0, 1};
    tv[3] = '{0, 1, 0, 0,  0, 58, 0, 0, 0, 0, 1};
    tv[4] = '{0, 0, 1, 0,  0, 59, 0, 0, 0, 0, 1};
    tv[5] = '{0, 0, 0, 0,  0, 59, 0, 0, 0, 0, 1};
    tv[6] = '{0, 0, 1, 0,  0,  0, 0, 0, 0, 0, 1};
    tv[7] = '{0, 0, 0, 1,  0,  0, 0, 0, 1, 0, 0};
    tv[8] = '{0, 0, 0, 0,  0,  0, 0, 0, 0, 0, 0};
    cyc = 0; act = 0; p1 = 0; p2 = 0; m_ch = 0;
    quiet();
    alarm_sel = 0; ore_curent = 0; minute_curent = 0;
    reset = 1;
    tick();
    tick();
    chk("rst_ore", int'(ore), 0);
    chk("rst_editing", int'(editing), 0);
    chk("rst_loads", int'({load_timp, load_alarma, timeout_abort}), 0);
    reset = 0;
    tick();
    ore_curent = 22; minute_curent = 58;
    for (int i = 0; i < 9; i++) begin
      semnal_setare = tv[i].setare[0]; semnal_b1 = tv[i].b1[0];
      semnal_b2 = tv[i].b2[0]; semnal_stop = tv[i].stop[0];
      tick();
      chk($sformatf("tv%0d_eo", i), int'(edit_ore), tv[i].eo);
      chk($sformatf("tv%0d_em", i), int'(edit_minute), tv[i].em);
      chk($sformatf("tv%0d_ore", i), int'(ore), tv[i].o);
      chk($sformatf("tv%0d_min", i), int'(minute), tv[i].m);
      chk($sformatf("tv%0d_lt", i), int'(load_timp), tv[i].lt);
      chk($sformatf("tv%0d_la", i), int'(load_alarma), tv[i].la);
      chk($sformatf("tv%0d_ed", i), int'(editing), tv[i].ed);
    end
    alarm_sel = 1; semnal_setare_a = 1; semnal_dir = 1;
    tick();
    semnal_setare_a = 0; semnal_b1 = 1; semnal_b2 = 1;
    tick();
    semnal_b1 = 0; semnal_b2 = 0;
    tick();
    semnal_stop = 1;
    tick();
    chk("alm_ore", int'(ore), 23);
    chk("alm_min", int'(minute), 59);
    chk("alm_load", int'(load_alarma), 2);
    semnal_stop = 0;
    tick();
    chk("alm_pulse_once", int'(load_alarma), 0);
    semnal_setare_a = 1;
    tick();
    chk("alm_pre_h", int'(edit_ore), 23);
    chk("alm_pre_m", int'(edit_minute), 59);
    semnal_setare_a = 0; semnal_cancel = 1;
    tick();
    quiet();
    ore_curent = 5; minute_curent = 7;
    semnal_setare = 1;
    tick();
    semnal_setare = 0; semnal_cancel = 1; semnal_stop = 1;
    tick();
    chk("cxl_lt", int'(load_timp), 0);
    chk("cxl_ed", int'(editing), 0);
    quiet();
    semnal_setare = 1;
    tick();
    semnal_setare = 0; semnal_b1 = 1;
    tick();
    semnal_b1 = 0;
    tick();
    semnal_b1 = 1; semnal_stop = 1;
    tick();
    chk("stop_edge_ore", int'(ore), 6);
    quiet();
    tick();
    semnal_setare = 1;
    tick();
    semnal_setare = 0; semnal_b1 = 1;
    repeat (10) tick();
    chk("held_b1", int'(edit_ore), 6);
    semnal_b1 = 0; semnal_cancel = 1;
    tick();
    quiet();
    ore_curent = 9; alarm_sel = 0; semnal_setare = 1; semnal_setare_a = 1;
    tick();
    chk("both_req_ed", int'(editing), 1);
    chk("both_req_eo", int'(edit_ore), 9);
    quiet();
    semnal_cancel = 1;
    tick();
    quiet();
    alarm_sel = 2; semnal_setare_a = 1;
    tick();
    chk("sel2_idle", int'(editing), 0);
    alarm_sel = 3;
    tick();
    chk("sel3_idle", int'(editing), 0);
    quiet();
    semnal_setare = 1;
    tick();
    semnal_setare = 0;
    n = 0;
    while (!timeout_abort && n < 40) begin tick(); n++; end
    chk("tmo_lat", n, 16);
    semnal_setare = 1;
    tick();
    semnal_setare = 0;
    repeat (10) tick();
    semnal_b2 = 1;
    tick();
    semnal_b2 = 0;
    n = 11;
    while (!timeout_abort && n < 60) begin tick(); n++; end
    chk("tmo_lat_edge", n, 26);
    semnal_setare = 1;
    tick();
    semnal_setare = 0; semnal_b1 = 1;
    tick();
    semnal_b1 = 0;
    tick();
    semnal_b1 = 1;
    tick();
    reset = 1; semnal_b1 = 0;
    tick();
    chk("rst_mid_ore", int'(ore), 0);
    chk("rst_mid_eo", int'(edit_ore), 0);
    chk("rst_mid_ed", int'(editing), 0);
    chk("rst_mid_lt", int'(load_timp), 0);
    reset = 0; alarm_sel = 1; semnal_setare_a = 1;
    tick();
    chk("rst_shadow_h", int'(edit_ore), 0);
    chk("rst_shadow_m", int'(edit_minute), 0);
    quiet();
    semnal_cancel = 1;
    tick();
    for (int i = 0; i < 4000; i++) begin
      reset = ($urandom_range(0, 299) == 0);
      semnal_setare = ($urandom_range(0, 9) == 0);
      semnal_setare_a = ($urandom_range(0, 7) == 0);
      alarm_sel = SW'($urandom_range(0, 3));
      semnal_b1 = $urandom_range(0, 1) == 1;
      semnal_b2 = $urandom_range(0, 2) == 0;
      semnal_dir = $urandom_range(0, 1) == 1;
      semnal_stop = ($urandom_range(0, 15) == 0);
      semnal_cancel = ($urandom_range(0, 39) == 0);
      ore_curent = 5'($urandom_range(0, HM));
      minute_curent = 6'($urandom_range(0, MM));
      tick();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/setare_multi.md
# setare_multi

Parametrised time/alarm setting controller for the clock datapath. It sits between the debounced push-buttons and the timekeeping and alarm-compare blocks. Entering an edit session preloads a working value: the current time for time edits, or the stored value of the selected alarm for alarm edits. Hours and minutes are stepped up or down on button rising edges, and the value is committed with a one-cycle load pulse to the time counter or to one of `NUM_ALARMS` alarm channels. Sessions can be cancelled explicitly or aborted by an inactivity timeout.

## Interface
- `NUM_ALARMS`, 2, number of alarm channels (1..8)
- `SEL_W`, 1, width of `alarm_sel`
- `HOUR_MAX`, 23, last hour value before wrap
- `MIN_MAX`, 59, last minute value before wrap
- `TIMEOUT_CYC`, 32'd500000000, inactivity cycles before abort; 0 disables
- `clock` in 1: single clock; all state on rising edge
- `reset` in 1: synchronous, active-high
- `semnal_setare` in 1: request time edit (level)
- `semnal_setare_a` in 1: request alarm edit (level)
- `alarm_sel` in `SEL_W`: alarm channel, captured on entry to alarm edit
- `semnal_b1` in 1: hour step button (level, debounced)
- `semnal_b2` in 1: minute step button (level, debounced)
- `semnal_dir` in 1: 0 = step up, 1 = step down
- `semnal_stop` in 1: commit session
- `semnal_cancel` in 1: abandon session
- `ore_curent` in 5, `minute_curent` in 6: live time, preload source for time edit
- `ore` out 5, `minute` out 6: committed value; valid in the load-pulse cycle and held afterwards
- `edit_ore` out 5, `edit_minute` out 6: working value for the display
- `load_timp` out 1: one-cycle commit pulse to the time counter
- `load_alarma` out `NUM_ALARMS`: one-hot, one-cycle commit pulse per alarm channel
- `editing` out 1: high in `EDIT_T` or `EDIT_A`
- `timeout_abort` out 1: one-cycle pulse when a session times out

## Operation
- FSM states: `IDLE`, `EDIT_T`, `EDIT_A`.
- `IDLE` transitions:
  - `semnal_setare` -> `EDIT_T`; working regs load `ore_curent`/`minute_curent`.
  - Otherwise `semnal_setare_a` with `alarm_sel` < `NUM_ALARMS` -> `EDIT_A`; channel index is latched; working regs load that channel's shadow register.
  - If both requests are high, time edit wins.
  - An out-of-range `alarm_sel` is ignored and the FSM stays in `IDLE`.
- Edge detection: `semnal_b1`/`semnal_b2` are registered every cycle in all states. An accepted edge is current = 1 while the previous sample = 0. Edges are acted on only in the EDIT states.
- Stepping:
  - b1 edge steps the hour; b2 edge steps the minute.
  - Simultaneous b1 and b2 edges both apply in the same cycle.
  - Up at `HOUR_MAX` -> 0; down at 0 -> `HOUR_MAX`. Same rule for minutes with `MIN_MAX`.
  - Wrap compares the working value, never the committed value.
- Exit priority, evaluated each cycle in EDIT: `reset` > `semnal_cancel` > `semnal_stop` > timeout > button edges.
  - Stop takes precedence over an edge in the same cycle; that edge is discarded.
  - Cancel: return to `IDLE`; no load pulse; `ore`/`minute` and shadows unchanged.
  - Stop in `EDIT_T`: `ore`/`minute` <= working value; pulse `load_timp`.
  - Stop in `EDIT_A`: additionally write the latched channel's shadow register; pulse `load_alarma[ch]`.
- Timeout counter:
  - Cleared on entry and on every accepted edge.
  - When it reaches `TIMEOUT_CYC` in EDIT -> `IDLE` with a `timeout_abort` pulse and no load.
- Request inputs are ignored while in EDIT. Re-entry from `IDLE` requires the request to be high in an `IDLE` cycle.

## Timing
- Reset values: all outputs 0, FSM `IDLE`, all alarm shadows 0, edge samples 0, timeout counter 0.
- Reset mid-session aborts it with no load pulse and clears the shadows.
- Entry: request high at cycle N in `IDLE` -> `editing` = 1 and preloaded `edit_*` visible at N+1.
- Step: edge detected at N -> updated `edit_*` at N+1.
- Commit: stop at N -> `ore`/`minute` updated and load pulse high at N+1 for exactly one cycle. `editing` = 0 at N+1.
- A request held high through commit starts a new session at N+2.
- Timeout: counter reaching `TIMEOUT_CYC` at cycle N -> `timeout_abort` and `editing` = 0 at N+1.
- A button held high produces exactly one step.
- Load outputs are never asserted together, and never more than one cycle per session.

## Test plan
- Time edit up-wrap: `ore_curent`=22, `minute_curent`=58; enter, two b1 edges, two b2 edges, stop -> `ore`=0, `minute`=0, `load_timp` one cycle, `load_alarma`=0.
- Alarm channel 1 down-wrap: `alarm_sel`=1, `semnal_dir`=1; one b1 edge and one b2 edge from shadow 0:00, stop -> `ore`=23, `minute`=59, `load_alarma`=2'b10. Re-enter channel 1 -> `edit_*` preload 23:59.
- Priority: cancel and stop in the same cycle -> no load pulse, `editing` = 0. Stop together with a b1 edge -> committed hour excludes that step.
- Held button: b1 high for 10 cycles -> hour increments by exactly 1. Both requests high in `IDLE` -> `EDIT_T`. `alarm_sel`=2 with `NUM_ALARMS`=2 -> stays `IDLE`.
- Timeout with `TIMEOUT_CYC`=16: enter, no activity -> `timeout_abort` 16 cycles after entry. A b2 edge at cycle 10 -> abort moves to cycle 26; no load pulse either way.
- Reset mid-session after two steps -> all outputs 0, shadows 0, no load pulse.
